// File: rtl/wiener_sched_pkg.sv
// Shared types and AXI constants for the block-wise Wiener filter scheduler.
package wiener_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_BLK,
        ST_ISSUE,
        ST_BURST,
        ST_GAP,
        ST_MEAN,
        ST_NEXT_BLK,
        ST_EOF
    } state_e;

    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/block_addr_gen.sv
// Block column/row and pixel-row counters plus the burst start address for the
// current position; frame geometry and base are captured on load.
module block_addr_gen
    import wiener_sched_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int BLOCK_SIZE      = 8,
    parameter int BYTES_PER_PIXEL = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  step_row_i,
    input  logic                  step_block_i,
    input  logic [15:0]           frame_width_i,
    input  logic [15:0]           frame_height_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    output logic [ADDR_WIDTH-1:0] read_addr_o,
    output logic                  last_row_o,
    output logic                  last_block_o,
    output logic                  first_block_o
);

    localparam int LOG2_B = $clog2(BLOCK_SIZE);
    localparam int LOG2_P = $clog2(BYTES_PER_PIXEL);

    logic [15:0]           width_q, bw_q, bh_q;
    logic [15:0]           bx_q, bx_d, by_q, by_d;
    logic [LOG2_B-1:0]     row_q, row_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] line_idx, pix_idx;
    logic                  last_col;

    assign last_col = (bx_q == bw_q - 16'd1);

    always_comb begin
        bx_d  = bx_q;
        by_d  = by_q;
        row_d = row_q;
        if (load_i) begin
            bx_d  = '0;
            by_d  = '0;
            row_d = '0;
        end else if (step_block_i) begin
            row_d = '0;
            if (last_col) begin
                bx_d = '0;
                by_d = by_q + 16'd1;
            end else begin
                bx_d = bx_q + 16'd1;
            end
        end else if (step_row_i) begin
            row_d = row_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_q <= '0;
            bw_q    <= '0;
            bh_q    <= '0;
            base_q  <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            row_q   <= '0;
        end else begin
            if (load_i) begin
                width_q <= frame_width_i;
                bw_q    <= frame_width_i >> LOG2_B;
                bh_q    <= frame_height_i >> LOG2_B;
                base_q  <= base_addr_i;
            end
            bx_q  <= bx_d;
            by_q  <= by_d;
            row_q <= row_d;
        end
    end

    // Power-of-two block edge and pixel size turn the scaling into shifts.
    assign line_idx    = (ADDR_WIDTH'(by_q) << LOG2_B) | ADDR_WIDTH'(row_q);
    assign pix_idx     = line_idx * ADDR_WIDTH'(width_q) + (ADDR_WIDTH'(bx_q) << LOG2_B);
    assign read_addr_o = base_q + (pix_idx << LOG2_P);

    assign last_row_o    = &row_q;
    assign last_block_o  = last_col && (by_q == bh_q - 16'd1);
    assign first_block_o = (bx_q == 16'd0) && (by_q == 16'd0);

endmodule

// File: rtl/wiener_block_scheduler.sv
// Walks one frame in 8x8-block raster order, issuing one INCR burst per block
// row and gating the Wiener filter enable around each burst.
module wiener_block_scheduler
    import wiener_sched_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int BLOCK_SIZE      = 8,
    parameter int BYTES_PER_PIXEL = 4,
    parameter int MEAN_CYCLES     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           frame_height,
    input  logic [15:0]           frame_width,
    input  logic [ADDR_WIDTH-1:0] base_addr_in,
    input  logic                  estimated_noise_ready,
    input  logic [15:0]           estimated_noise_in,
    input  logic                  rvalid,
    input  logic                  rlast,
    output logic                  start_read,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic [31:0]           read_len,
    output logic [2:0]            read_size,
    output logic [1:0]            read_burst,
    output logic                  wiener_en,
    output logic                  start_data,
    output logic                  start_of_frame,
    output logic                  end_of_frame,
    output logic [15:0]           noise_variance_out,
    output logic [31:0]           blocks_per_frame,
    output logic                  busy
);

    localparam int LOG2_B = $clog2(BLOCK_SIZE);
    localparam int MCW    = (MEAN_CYCLES < 2) ? 1 : $clog2(MEAN_CYCLES);

    state_e                state_q, state_d;
    logic [MCW-1:0]        mean_cnt_q, mean_cnt_d;
    logic [15:0]           noise_q;
    logic [31:0]           bpf_q, bpf_in;
    logic [ADDR_WIDTH-1:0] read_addr_q, next_addr;
    logic                  start_frame, burst_done;
    logic                  last_row, last_block, first_block;

    assign bpf_in      = 32'(frame_height >> LOG2_B) * 32'(frame_width >> LOG2_B);
    assign start_frame = (state_q == ST_IDLE) && estimated_noise_ready;
    assign burst_done  = (state_q == ST_BURST) && rvalid && rlast;

    block_addr_gen #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .BLOCK_SIZE      (BLOCK_SIZE),
        .BYTES_PER_PIXEL (BYTES_PER_PIXEL)
    ) u_addr (
        .clk            (clk),
        .rst            (rst),
        .load_i         (start_frame),
        .step_row_i     (burst_done && !last_row),
        .step_block_i   (state_q == ST_NEXT_BLK),
        .frame_width_i  (frame_width),
        .frame_height_i (frame_height),
        .base_addr_i    (base_addr_in),
        .read_addr_o    (next_addr),
        .last_row_o     (last_row),
        .last_block_o   (last_block),
        .first_block_o  (first_block)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mean_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mean_cnt_q <= mean_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mean_cnt_d = '0;
        case (state_q)
            ST_IDLE:      if (start_frame) state_d = (bpf_in == 32'd0) ? ST_EOF : ST_START_BLK;
            ST_START_BLK: state_d = ST_ISSUE;
            ST_ISSUE:     state_d = ST_BURST;
            ST_BURST: begin
                if (burst_done) begin
                    if (!last_row)             state_d = ST_GAP;
                    else if (MEAN_CYCLES == 0) state_d = ST_NEXT_BLK;
                    else                       state_d = ST_MEAN;
                end
            end
            ST_GAP:       state_d = ST_ISSUE;
            ST_MEAN: begin
                mean_cnt_d = mean_cnt_q + 1'b1;
                if (mean_cnt_q == MCW'(MEAN_CYCLES - 1)) state_d = ST_NEXT_BLK;
            end
            ST_NEXT_BLK:  state_d = last_block ? ST_EOF : ST_START_BLK;
            ST_EOF:       state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start_read     = (state_q == ST_ISSUE);
        start_data     = (state_q == ST_START_BLK);
        start_of_frame = (state_q == ST_START_BLK) && first_block;
        end_of_frame   = (state_q == ST_EOF);
        wiener_en      = (state_q == ST_START_BLK) || (state_q == ST_ISSUE) ||
                         (state_q == ST_BURST)     || (state_q == ST_MEAN);
        busy           = (state_q != ST_IDLE) && (state_q != ST_EOF);
    end

    // The address is captured on entry to ISSUE so it stays put while the
    // counters move on during the following GAP/NEXT_BLK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            noise_q     <= '0;
            bpf_q       <= '0;
            read_addr_q <= '0;
        end else begin
            if (start_frame) begin
                noise_q <= estimated_noise_in;
                bpf_q   <= bpf_in;
            end
            if (state_d == ST_ISSUE) read_addr_q <= next_addr;
        end
    end

    assign read_addr          = read_addr_q;
    assign noise_variance_out = noise_q;
    assign blocks_per_frame   = bpf_q;
    assign read_len           = 32'(BLOCK_SIZE - 1);
    assign read_size          = SIZE_4B;
    assign read_burst         = BURST_INCR;

endmodule

// File: tb/tb_wiener_block_scheduler.sv
// Randomised bench for wiener_block_scheduler: a timeline model derived from the
// frame walk rules predicts every output each cycle, plus pinned literal checks.
module tb_wiener_block_scheduler;

    localparam int BS    = 8;
    localparam int BPP   = 4;
    localparam int MEANC = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] frame_height, frame_width;
    logic [31:0] base_addr_in;
    logic        estimated_noise_ready;
    logic [15:0] estimated_noise_in;
    logic        rvalid, rlast;
    logic        start_read, wiener_en, start_data, start_of_frame, end_of_frame, busy;
    logic [31:0] read_addr, read_len, blocks_per_frame;
    logic [2:0]  read_size;
    logic [1:0]  read_burst;
    logic [15:0] noise_variance_out;

    wiener_block_scheduler #(
        .ADDR_WIDTH(32), .BLOCK_SIZE(BS), .BYTES_PER_PIXEL(BPP), .MEAN_CYCLES(MEANC)
    ) dut (
        .clk(clk), .rst(rst),
        .frame_height(frame_height), .frame_width(frame_width), .base_addr_in(base_addr_in),
        .estimated_noise_ready(estimated_noise_ready), .estimated_noise_in(estimated_noise_in),
        .rvalid(rvalid), .rlast(rlast),
        .start_read(start_read), .read_addr(read_addr), .read_len(read_len),
        .read_size(read_size), .read_burst(read_burst), .wiener_en(wiener_en),
        .start_data(start_data), .start_of_frame(start_of_frame), .end_of_frame(end_of_frame),
        .noise_variance_out(noise_variance_out), .blocks_per_frame(blocks_per_frame), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Model: frame position plus a per-cycle schedule of expected events.
    bit          m_active = 0, m_in_burst = 0;
    int          m_end = 0, m_W = 0, m_bw = 0, m_bpf = 0, m_k = 0, m_r = 0;
    longint      m_base = 0;
    logic [15:0] m_noise = '0;
    logic [31:0] m_cur_addr = '0;
    logic [31:0] exp_sr[int];
    bit          exp_sd[int];
    bit          exp_low[int];

    logic [31:0] obs_addr[$];
    int          obs_sd, obs_sof, obs_sof_first, obs_eof, obs_eof_cyc, pulse_cyc;

    function automatic logic [31:0] blk_addr(input int k, input int r);
        longint bx, by, a;
        bx = k % m_bw;
        by = k / m_bw;
        a  = m_base + ((by * BS + r) * m_W + bx * BS) * BPP;
        return a[31:0];
    endfunction

    always @(negedge clk) begin : cmp
        bit e_busy;
        chk("read_len", read_len, BS - 1);
        chk("read_size", read_size, 3'b010);
        chk("read_burst", read_burst, 2'b01);
        if (rst) begin
            chk("rst_start_read", start_read, 0);
            chk("rst_wiener_en", wiener_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_end_of_frame", end_of_frame, 0);
            chk("rst_read_addr", read_addr, 0);
            chk("rst_noise", noise_variance_out, 0);
            chk("rst_bpf", blocks_per_frame, 0);
            m_active = 0; m_in_burst = 0; m_cur_addr = '0; m_noise = '0; m_bpf = 0;
            exp_sr.delete(); exp_sd.delete(); exp_low.delete();
        end else begin
            e_busy = m_active && (cyc < m_end);
            if (exp_sr.exists(cyc)) m_cur_addr = exp_sr[cyc];
            chk("start_read", start_read, exp_sr.exists(cyc));
            chk("start_data", start_data, exp_sd.exists(cyc));
            chk("start_of_frame", start_of_frame, exp_sd.exists(cyc) && exp_sd[cyc]);
            chk("end_of_frame", end_of_frame, m_active && (cyc == m_end));
            chk("busy", busy, e_busy);
            chk("wiener_en", wiener_en, e_busy && !exp_low.exists(cyc));
            chk("read_addr", read_addr, m_cur_addr);
            chk("noise_variance_out", noise_variance_out, m_noise);
            chk("blocks_per_frame", blocks_per_frame, m_bpf);

            if (start_read) begin
                obs_addr.push_back(read_addr);
                $display("issue  cyc=%0d addr=%08h", cyc, read_addr);
            end
            if (start_data) obs_sd++;
            if (start_of_frame) begin
                obs_sof++;
                if (start_data && obs_sd == 1) obs_sof_first++;
            end
            if (end_of_frame) begin
                obs_eof++;
                obs_eof_cyc = cyc;
                $display("eof    cyc=%0d", cyc);
            end

            if (m_active && m_in_burst && rvalid && rlast) begin
                m_in_burst = 0;
                if (m_r < BS - 1) begin
                    exp_low[cyc + 1] = 1;
                    m_r++;
                    exp_sr[cyc + 2] = blk_addr(m_k, m_r);
                end else begin
                    exp_low[cyc + MEANC + 1] = 1;
                    if (m_k < m_bpf - 1) begin
                        m_k++;
                        m_r = 0;
                        exp_sd[cyc + MEANC + 2] = 0;
                        exp_sr[cyc + MEANC + 3] = blk_addr(m_k, 0);
                    end else begin
                        m_end = cyc + MEANC + 2;
                    end
                end
            end
            if (exp_sr.exists(cyc)) m_in_burst = 1;
            if (estimated_noise_ready && !m_active) begin
                m_W     = frame_width;
                m_bw    = frame_width / BS;
                m_bpf   = (frame_height / BS) * (frame_width / BS);
                m_base  = base_addr_in;
                m_noise = estimated_noise_in;
                m_k = 0; m_r = 0; m_active = 1;
                if (m_bpf == 0) begin
                    m_end = cyc + 1;
                end else begin
                    m_end = 32'h7fff_ffff;
                    exp_sd[cyc + 1] = 1;
                    exp_sr[cyc + 2] = blk_addr(0, 0);
                end
            end else if (m_active && cyc == m_end) begin
                m_active = 0;
            end
        end
    end

    // Read slave: 2-cycle address latency, 8 beats with random gaps and stray rlast.
    initial begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        forever begin
            @(negedge clk);
            if (start_read === 1'b1) begin
                repeat (2) @(posedge clk);
                for (int b = 0; b < BS; b++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                        rvalid = 1'b0;
                        rlast  = ($urandom_range(0, 3) == 0);
                    end
                    @(posedge clk); #1;
                    rvalid = 1'b1;
                    rlast  = (b == BS - 1);
                end
                @(posedge clk); #1;
                rvalid = 1'b0;
                rlast  = 1'b0;
            end
        end
    end

    task automatic clear_obs();
        obs_addr.delete();
        obs_sd = 0; obs_sof = 0; obs_sof_first = 0; obs_eof = 0; obs_eof_cyc = -1;
    endtask

    task automatic pulse(input int w, input int h, input logic [31:0] base, input logic [15:0] noise);
        @(posedge clk); #1;
        frame_width           = 16'(w);
        frame_height          = 16'(h);
        base_addr_in          = base;
        estimated_noise_in    = noise;
        estimated_noise_ready = 1'b1;
        pulse_cyc             = cyc;
        @(posedge clk); #1;
        estimated_noise_ready = 1'b0;
        frame_width           = 16'($urandom);
        frame_height          = 16'($urandom);
        base_addr_in          = $urandom;
        estimated_noise_in    = 16'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (m_active && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("frame_done_in_budget", m_active, 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_addrs(input int cnt, input int budget);
        int n = 0;
        while (obs_addr.size() < cnt && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("issue_wait_in_budget", obs_addr.size() >= cnt, 1);
    endtask

    initial begin
        rst = 1'b1;
        frame_height = '0; frame_width = '0; base_addr_in = '0;
        estimated_noise_ready = 1'b0; estimated_noise_in = '0;
        clear_obs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 16x16 frame, with a pulse carrying noise 999 mid-frame that must be ignored.
        clear_obs();
        pulse(16, 16, 32'h0, 16'd5386);
        wait_addrs(10, 2000);
        pulse(40, 40, 32'h100, 16'd999);
        wait_done(5000);
        chk("t1_bpf", blocks_per_frame, 4);
        chk("t1_noise", noise_variance_out, 5386);
        chk("t1_issue_count", obs_addr.size(), 32);
        if (obs_addr.size() == 32) begin
            for (int r = 0; r < 8; r++) chk("t1_blk0_row_addr", obs_addr[r], r * 64);
            chk("t1_blk1_addr", obs_addr[8], 32);
            chk("t1_blk2_addr", obs_addr[16], 512);
            chk("t1_blk3_addr", obs_addr[24], 544);
        end
        chk("t1_eof_count", obs_eof, 1);
        chk("t1_start_data_count", obs_sd, 4);
        chk("t1_sof_count", obs_sof, 1);
        chk("t1_sof_with_first_block", obs_sof_first, 1);

        // 20x12: two blocks, 80-byte line stride.
        clear_obs();
        pulse(20, 12, 32'h0, 16'd42);
        wait_done(3000);
        chk("t2_bpf", blocks_per_frame, 2);
        chk("t2_issue_count", obs_addr.size(), 16);
        if (obs_addr.size() == 16) begin
            chk("t2_row0", obs_addr[0], 0);
            chk("t2_row1", obs_addr[1], 80);
            chk("t2_blk1", obs_addr[8], 32);
        end

        // Zero-block frame: end_of_frame in the cycle after the pulse cycle.
        clear_obs();
        pulse(16, 4, 32'h40, 16'd7);
        wait_done(100);
        chk("t3_bpf", blocks_per_frame, 0);
        chk("t3_eof_delay", obs_eof_cyc - pulse_cyc, 1);
        chk("t3_eof_count", obs_eof, 1);
        chk("t3_issue_count", obs_addr.size(), 0);

        // Asynchronous reset during the third burst, then a clean restart.
        clear_obs();
        pulse(16, 16, 32'h1000, 16'd77);
        wait_addrs(3, 1000);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t4_busy_now", busy, 0);
        chk("t4_wiener_en_now", wiener_en, 0);
        chk("t4_read_addr_now", read_addr, 0);
        chk("t4_noise_now", noise_variance_out, 0);
        chk("t4_bpf_now", blocks_per_frame, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        chk("t4_no_eof_after_abort", obs_eof, 0);
        clear_obs();
        pulse(16, 16, 32'h1000, 16'd77);
        wait_done(5000);
        chk("t4_restart_issue_count", obs_addr.size(), 32);
        if (obs_addr.size() > 0) chk("t4_restart_addr", obs_addr[0], 32'h1000);
        chk("t4_restart_eof", obs_eof, 1);

        // Random geometries, bases and noise values.
        for (int f = 0; f < 4; f++) begin
            int w, h;
            w = $urandom_range(0, 48);
            h = $urandom_range(0, 48);
            $display("frame  %0dx%0d", w, h);
            clear_obs();
            pulse(w, h, $urandom & 32'hffff_fffc, 16'($urandom));
            wait_done(20000);
            chk("rnd_issue_count", obs_addr.size(), (w / BS) * (h / BS) * BS);
            chk("rnd_eof_count", obs_eof, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
